mips_if_fetch_ctrl: RTL and testbench

Fetch sequencer for the IF stage. Owns the PC, issues one instruction-memory request at a time, and feeds each returned instruction through the IF mini-decoder. It uses the decoded BJP info to predict the next PC and drives the IF->ID pipeline register with a valid/ready handshake. EX-stage redirects (mispredict, exception) flush it; jr/jalr stall until the rs operand is free.

---
 rtl/mips_if_fetch_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mips_if_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, keeps a single imem request in flight,
// predicts the next PC from the mini-decoder flags and fills the IF->ID register.
//
// state | meaning
// REQ   | offer pc_q to imem (held off while a stale response is still due)
// WAIT  | request accepted, waiting for its instruction
// HOLD  | instruction parked in hold_inst_q until the IF->ID slot frees
// JRW   | jr/jalr parked until its rs operand has no in-flight write
module mips_if_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  output logic [INST_W-1:0] md_inst,
  output logic [ADDR_W-1:0] md_pc_incr,
  input  logic              md_j,
  input  logic              md_jr,
  input  logic              md_jal,
  input  logic              md_jalr,
  input  logic              md_bxx,
  input  logic [ADDR_W-1:0] md_j_imm,
  input  logic [ADDR_W-1:0] md_b_imm,
  input  logic              jr_rs_busy,
  input  logic [ADDR_W-1:0] jr_rs_data,
  input  logic              ex_flush,
  input  logic [ADDR_W-1:0] ex_flush_pc,
  output logic              if2id_valid,
  input  logic              if2id_ready,
  output logic [INST_W-1:0] if2id_inst,
  output logic [ADDR_W-1:0] if2id_pc_incr,
  output logic              if2id_prdt_taken
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_JRW} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                drop_q, drop_d;
  logic [INST_W-1:0]   hold_inst_q, hold_inst_d;
  logic                if2id_valid_q, if2id_valid_d;
  logic [INST_W-1:0]   if2id_inst_q, if2id_inst_d;
  logic [ADDR_W-1:0]   if2id_pc_incr_q, if2id_pc_incr_d;
  logic                if2id_taken_q, if2id_taken_d;

  logic [ADDR_W-1:0]   pc_incr;
  logic [ADDR_W-1:0]   pred_pc;
  logic                pred_taken;
  logic                req_fire;
  logic                slot_free;
  logic                is_jmp;
  logic                is_jr;
  logic                jr_stall;
  logic                evaluate;

  // pc_q stays at the fetched instruction's PC until it has been evaluated
  assign pc_incr        = pc_q + PC_STEP;
  assign md_pc_incr     = pc_incr;
  assign md_inst        = (state_q == S_WAIT) ? imem_rsp_inst : hold_inst_q;

  // rst_n gating keeps the request low for the whole reset window
  assign imem_req_valid = rst_n & (state_q == S_REQ) & ~drop_q;
  assign imem_req_addr  = align_pc(pc_q);
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign slot_free      = ~if2id_valid_q | if2id_ready;
  assign is_jmp         = md_j | md_jal;
  assign is_jr          = md_jr | md_jalr;
  assign jr_stall       = ~is_jmp & is_jr & jr_rs_busy;

  always_comb begin
    pred_pc    = pc_incr;
    pred_taken = 1'b0;
    if (is_jmp) begin
      pred_pc    = md_j_imm;
      pred_taken = 1'b1;
    end else if (is_jr) begin
      pred_pc    = jr_rs_data;
      pred_taken = 1'b1;
    end else if (md_bxx && (md_b_imm < pc_incr)) begin
      pred_pc    = md_b_imm;
      pred_taken = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drop_d          = drop_q;
    hold_inst_d     = hold_inst_q;
    if2id_valid_d   = if2id_valid_q & ~if2id_ready;
    if2id_inst_d    = if2id_inst_q;
    if2id_pc_incr_d = if2id_pc_incr_q;
    if2id_taken_d   = if2id_taken_q;
    evaluate        = 1'b0;

    if (drop_q && imem_rsp_valid) begin
      drop_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid && !drop_q) begin
          evaluate    = 1'b1;
          hold_inst_d = imem_rsp_inst;
        end
      end
      S_HOLD, S_JRW: begin
        evaluate = 1'b1;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (evaluate) begin
      if (jr_stall) begin
        state_d = S_JRW;
      end else if (slot_free) begin
        state_d         = S_REQ;
        pc_d            = align_pc(pred_pc);
        if2id_valid_d   = 1'b1;
        if2id_inst_d    = md_inst;
        if2id_pc_incr_d = pc_incr;
        if2id_taken_d   = pred_taken;
      end else begin
        state_d = S_HOLD;
      end
    end

    // A flush leaves at most one response still owed by imem; drop_d marks it stale
    if (ex_flush) begin
      state_d       = S_REQ;
      pc_d          = align_pc(ex_flush_pc);
      if2id_valid_d = 1'b0;
      hold_inst_d   = '0;
      drop_d        = req_fire
                    | ((state_q == S_WAIT) & ~imem_rsp_valid)
                    | (drop_q & ~imem_rsp_valid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_REQ;
      pc_q            <= align_pc(RESET_PC);
      drop_q          <= 1'b0;
      hold_inst_q     <= '0;
      if2id_valid_q   <= 1'b0;
      if2id_inst_q    <= '0;
      if2id_pc_incr_q <= '0;
      if2id_taken_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      drop_q          <= drop_d;
      hold_inst_q     <= hold_inst_d;
      if2id_valid_q   <= if2id_valid_d;
      if2id_inst_q    <= if2id_inst_d;
      if2id_pc_incr_q <= if2id_pc_incr_d;
      if2id_taken_q   <= if2id_taken_d;
    end
  end

  assign if2id_valid      = if2id_valid_q;
  assign if2id_inst       = if2id_inst_q;
  assign if2id_pc_incr    = if2id_pc_incr_q;
  assign if2id_prdt_taken = if2id_taken_q;

endmodule

// File: tb/tb_mips_if_fetch_ctrl.sv
// Bench for mips_if_fetch_ctrl: imem model, ID consumer, MIPS mini-decoder and an
// architectural next-PC reference model; directed scenarios then a randomized run.
module tb_mips_if_fetch_ctrl;

  localparam logic [31:0] JR_TARGET = 32'h0000_0200;
  localparam logic [31:0] ALU_INST  = 32'h0109_5020;

  localparam logic [31:0] EXP_REQ [14] = '{
    32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h100, 32'h104,
    32'h040, 32'h020, 32'h024, 32'h048, 32'h04C, 32'h050, 32'h200};
  localparam logic [32:0] EXP_ID [14] = '{
    {1'b0, 32'h004}, {1'b0, 32'h008}, {1'b0, 32'h00C}, {1'b0, 32'h010},
    {1'b1, 32'h014}, {1'b0, 32'h104}, {1'b1, 32'h108}, {1'b1, 32'h044},
    {1'b0, 32'h024}, {1'b1, 32'h028}, {1'b0, 32'h04C}, {1'b0, 32'h050},
    {1'b1, 32'h054}, {1'b0, 32'h204}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_inst = 32'h0;
  logic [31:0] md_inst;
  logic [31:0] md_pc_incr;
  logic        md_j, md_jr, md_jal, md_jalr, md_bxx;
  logic [31:0] md_j_imm, md_b_imm;
  logic        jr_rs_busy = 1'b0;
  logic [31:0] jr_rs_data = JR_TARGET;
  logic        ex_flush = 1'b0;
  logic [31:0] ex_flush_pc = 32'h0;
  logic        if2id_valid;
  logic        if2id_ready = 1'b0;
  logic [31:0] if2id_inst;
  logic [31:0] if2id_pc_incr;
  logic        if2id_prdt_taken;

  always #5 clk = ~clk;

  mips_if_fetch_ctrl #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_inst(imem_rsp_inst), .md_inst(md_inst), .md_pc_incr(md_pc_incr),
    .md_j(md_j), .md_jr(md_jr), .md_jal(md_jal), .md_jalr(md_jalr), .md_bxx(md_bxx),
    .md_j_imm(md_j_imm), .md_b_imm(md_b_imm),
    .jr_rs_busy(jr_rs_busy), .jr_rs_data(jr_rs_data),
    .ex_flush(ex_flush), .ex_flush_pc(ex_flush_pc),
    .if2id_valid(if2id_valid), .if2id_ready(if2id_ready), .if2id_inst(if2id_inst),
    .if2id_pc_incr(if2id_pc_incr), .if2id_prdt_taken(if2id_prdt_taken)
  );

  // Mini-decoder standing in for the real one
  always_comb begin
    md_j     = (md_inst[31:26] == 6'h02);
    md_jal   = (md_inst[31:26] == 6'h03);
    md_jr    = (md_inst[31:26] == 6'h00) && (md_inst[5:0] == 6'h08);
    md_jalr  = (md_inst[31:26] == 6'h00) && (md_inst[5:0] == 6'h09);
    md_bxx   = (md_inst[31:26] == 6'h04) || (md_inst[31:26] == 6'h05);
    md_j_imm = {md_pc_incr[31:28], md_inst[25:0], 2'b00};
    md_b_imm = md_pc_incr + {{14{md_inst[15]}}, md_inst[15:0], 2'b00};
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] imem [1024];
  logic [31:0] req_log [$];
  logic [32:0] id_log [$];

  bit          knob_rand = 1'b0;
  bit          force_id_ready = 1'b1;
  bit          force_busy = 1'b0;
  bit          force_flush = 1'b0;
  logic [31:0] force_flush_pc = 32'h0;
  int          dir_lat = 1;

  bit          outstanding;
  int          cnt;
  logic [31:0] rsp_addr;
  logic [31:0] req_model_pc, id_model_pc;
  bit          prev_stall;
  logic [65:0] saved_if2id;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Architectural next PC: {taken, next_pc}
  function automatic logic [32:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] seq, tgt;
    seq = pc + 32'd4;
    if (inst[31:26] == 6'h02 || inst[31:26] == 6'h03)
      return {1'b1, seq[31:28], inst[25:0], 2'b00};
    if (inst[31:26] == 6'h00 && (inst[5:0] == 6'h08 || inst[5:0] == 6'h09))
      return {1'b1, JR_TARGET};
    if (inst[31:26] == 6'h04 || inst[31:26] == 6'h05) begin
      tgt = seq + (32'($signed(inst[15:0])) << 2);
      if (tgt < seq) return {1'b1, tgt};
    end
    return {1'b0, seq};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] a);
    return {6'h02, a[27:2]};
  endfunction

  function automatic logic [31:0] enc_beq(input int off);
    return {6'h04, 5'd1, 5'd2, 16'(off)};
  endfunction

  // One clock: drive inputs at negedge, then observe the handshakes of the next posedge
  task automatic cycle();
    logic [32:0] nx;
    @(negedge clk);
    if (!rst_n) begin
      outstanding = 1'b0; cnt = 0; imem_rsp_valid = 1'b0; ex_flush = 1'b0;
      imem_req_ready = 1'b0; if2id_ready = 1'b0; jr_rs_busy = 1'b0;
      req_model_pc = 32'h0; id_model_pc = 32'h0; prev_stall = 1'b0;
      return;
    end
    imem_rsp_valid = 1'b0;
    if (outstanding) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_inst  = imem[rsp_addr[11:2]];
        outstanding    = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (knob_rand) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if2id_ready    = ($urandom_range(0, 3) != 0);
      jr_rs_busy     = ($urandom_range(0, 2) == 0);
      ex_flush       = ($urandom_range(0, 39) == 0);
      ex_flush_pc    = 32'($urandom_range(0, 4095));
    end else begin
      imem_req_ready = 1'b1;
      if2id_ready    = force_id_ready;
      jr_rs_busy     = force_busy;
      ex_flush       = force_flush;
      ex_flush_pc    = force_flush_pc;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      check("req_single_outstanding", 96'(outstanding), 96'(0));
      check("req_addr", 96'(imem_req_addr), 96'(req_model_pc));
      req_log.push_back(imem_req_addr);
      nx           = model_next(req_model_pc, imem[req_model_pc[11:2]]);
      req_model_pc = nx[31:0];
      outstanding  = 1'b1;
      rsp_addr     = imem_req_addr;
      cnt          = knob_rand ? int'($urandom_range(0, 2)) : dir_lat - 1;
    end
    if (prev_stall)
      check("if2id_stable", 96'({if2id_valid, if2id_prdt_taken, if2id_inst, if2id_pc_incr}),
            96'(saved_if2id));
    if (if2id_valid && if2id_ready) begin
      nx = model_next(id_model_pc, imem[id_model_pc[11:2]]);
      check("if2id_data", 96'({if2id_prdt_taken, if2id_inst, if2id_pc_incr}),
            96'({nx[32], imem[id_model_pc[11:2]], id_model_pc + 32'd4}));
      id_log.push_back({if2id_prdt_taken, if2id_pc_incr});
      id_model_pc = nx[31:0];
    end
    prev_stall  = if2id_valid && !if2id_ready && !ex_flush;
    saved_if2id = {if2id_valid, if2id_prdt_taken, if2id_inst, if2id_pc_incr};
    if (ex_flush) begin
      req_model_pc = {ex_flush_pc[31:2], 2'b00};
      id_model_pc  = {ex_flush_pc[31:2], 2'b00};
    end
  endtask

  initial begin
    int n;
    int n0;
    for (int i = 0; i < 1024; i++) imem[i] = ALU_INST;
    imem[4]   = enc_j(32'h100);
    imem[65]  = enc_j(32'h040);
    imem[16]  = enc_beq(-9);
    imem[9]   = enc_j(32'h048);
    imem[18]  = enc_beq(13);
    imem[20]  = {6'd0, 5'd31, 15'd0, 6'h08};
    imem[129] = enc_j(32'h204);

    #3;
    check("rst_req_valid", 96'(imem_req_valid), 96'(0));
    check("rst_req_addr", 96'(imem_req_addr), 96'(0));
    check("rst_if2id_valid", 96'(if2id_valid), 96'(0));
    check("rst_if2id_inst", 96'(if2id_inst), 96'(0));
    check("rst_if2id_pc_incr", 96'(if2id_pc_incr), 96'(0));
    check("rst_if2id_taken", 96'(if2id_prdt_taken), 96'(0));
    cycle();

    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("first_req_valid", 96'(imem_req_valid), 96'(1));
    check("first_req_addr", 96'(imem_req_addr), 96'(0));

    force_id_ready = 1'b0;
    repeat (8) cycle();
    check("stall_req_count", 96'(req_log.size()), 96'(2));
    check("stall_if2id_valid", 96'(if2id_valid), 96'(1));
    check("stall_if2id_pc_incr", 96'(if2id_pc_incr), 96'(32'h4));
    check("stall_if2id_inst", 96'(if2id_inst), 96'(ALU_INST));

    force_id_ready = 1'b1;
    force_busy     = 1'b1;
    for (int c = 0; c < 200 && req_log.size() < 13; c++) cycle();
    check("jr_reached", 96'(req_log.size()), 96'(13));
    repeat (6) cycle();
    check("jr_stall_no_new_req", 96'(req_log.size()), 96'(13));
    check("jr_stall_req_valid", 96'(imem_req_valid), 96'(0));
    force_busy = 1'b0;
    for (int c = 0; c < 10 && req_log.size() < 14; c++) cycle();
    check("jr_target_req", 96'((req_log.size() >= 14) ? req_log[13] : 32'hFFFF_FFFF),
          96'(JR_TARGET));
    for (int c = 0; c < 20 && id_log.size() < 14; c++) cycle();
    check("dir_id_count", 96'(id_log.size()), 96'(14));
    for (int i = 0; i < 14; i++) begin
      check($sformatf("dir_req_%0d", i), 96'(req_log[i]), 96'(EXP_REQ[i]));
      check($sformatf("dir_id_%0d", i), 96'((i < id_log.size()) ? id_log[i] : 33'h1_FFFF_FFFF),
            96'(EXP_ID[i]));
    end

    dir_lat = 2;
    n = req_log.size();
    for (int c = 0; c < 50 && req_log.size() == n; c++) cycle();
    force_flush    = 1'b1;
    force_flush_pc = 32'h0000_0403;
    cycle();
    force_flush = 1'b0;
    cycle();
    check("flush_rsp_cycle_no_req", 96'(imem_req_valid), 96'(0));
    check("flush_if2id_valid", 96'(if2id_valid), 96'(0));
    cycle();
    check("flush_target_req", 96'(req_log[req_log.size() - 1]), 96'(32'h400));
    for (int c = 0; c < 20 && !if2id_valid; c++) cycle();
    check("flush_first_pc_incr", 96'(if2id_pc_incr), 96'(32'h404));

    n = req_log.size();
    for (int c = 0; c < 50 && req_log.size() == n; c++) cycle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 96'(imem_req_valid), 96'(0));
    check("midrst_req_addr", 96'(imem_req_addr), 96'(0));
    check("midrst_if2id_valid", 96'(if2id_valid), 96'(0));
    check("midrst_if2id_inst", 96'(if2id_inst), 96'(0));
    check("midrst_if2id_pc_incr", 96'(if2id_pc_incr), 96'(0));
    check("midrst_if2id_taken", 96'(if2id_prdt_taken), 96'(0));

    for (int i = 0; i < 1024; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 55)      imem[i] = {6'h00, 20'($urandom), 6'h20};
      else if (r < 65) imem[i] = enc_j(32'($urandom_range(0, 4095)));
      else if (r < 70) imem[i] = {6'h03, 26'($urandom_range(0, 1023))};
      else if (r < 82) imem[i] = enc_beq(int'($urandom_range(0, 63)) - 32);
      else if (r < 86) imem[i] = {6'h05, 10'($urandom), 16'(int'($urandom_range(0, 63)) - 32)};
      else if (r < 93) imem[i] = {6'd0, 5'($urandom), 15'd0, 6'h08};
      else             imem[i] = {6'd0, 5'($urandom), 5'd0, 5'd31, 5'd0, 6'h09};
    end
    cycle();
    knob_rand = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = id_log.size();
    repeat (4000) cycle();
    check("rand_progress", 96'((id_log.size() - n0) > 200), 96'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
